// File: rtl/seg_scan_controller_if.sv
// Bus bundle between the display scan controller and whoever owns the number
// being shown (normally the bank FSM). The master drives the value and its
// load handshake; the slave (the controller) returns the decoder/anode drive.
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      blank_lz;
    logic                      load_ack;
    logic [7:0]                digit_code;
    logic [NUM_DIGITS-1:0]     anode;
    logic [2:0]                digit_idx;

    modport master (
        output enable, load, value, blank_lz,
        input  load_ack, digit_code, anode, digit_idx
    );

    modport slave (
        input  enable, load, value, blank_lz,
        output load_ack, digit_code, anode, digit_idx
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scan controller. One digit nibble at a time
// is presented to the shared decoder while its anode is selected. New values
// are only adopted at frame boundaries so a frame never mixes two numbers.
module seg_scan_controller #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_controller_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic [VW-1:0]         pend_val_q, pend_val_d;
    logic                  pend_flag_q, pend_flag_d;
    logic                  load_ack_q, load_ack_d;
    logic [7:0]            code_q, code_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;

    // Frame-boundary detection and the value that the next digit update shows
    logic                  last_dwell;
    logic                  wrap;
    logic                  adopt;
    logic [VW-1:0]         adopt_val;
    logic [VW-1:0]         disp_val;
    logic [2:0]            step_idx;
    logic [8*NUM_DIGITS-1:0] code_all;
    logic [7:0]            sel_code;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [NUM_DIGITS-1:0] sel_anode;

    assign last_dwell = (cnt_q == CW'(REFRESH_DIV - 1));
    // Dropping enable cancels the digit advance, so it also cancels the wrap.
    assign wrap       = (state_q == SCAN) && bus.enable && last_dwell &&
                        (idx_q == 3'(NUM_DIGITS - 1));
    assign adopt      = ((state_q == IDLE) || wrap) && (bus.load || pend_flag_q);
    // A load arriving on the adoption edge bypasses the pending register.
    assign adopt_val  = bus.load ? bus.value : pend_val_q;
    assign disp_val   = adopt ? adopt_val : shadow_q;

    // Per-digit decoder code: invalid nibbles and leading zeros go blank (8'hFF)
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam bit CAN_BLANK = (gi != 0);
            logic [3:0] nib;
            logic       upper_zero;
            assign nib        = disp_val[4*gi +: 4];
            assign upper_zero = (disp_val[VW-1:4*gi] == '0);
            assign code_all[8*gi +: 8] =
                (nib > 4'd9)                                ? 8'hFF :
                (bus.blank_lz && CAN_BLANK && upper_zero)   ? 8'hFF :
                                                              {4'b0000, nib};
        end
    endgenerate

    // Index of the digit that the next digit update will select
    always_comb begin
        step_idx = 3'd0;
        if ((state_q == SCAN) && (idx_q != 3'(NUM_DIGITS - 1))) begin
            step_idx = idx_q + 3'd1;
        end
    end

    // Code and anode pattern for the digit at step_idx
    always_comb begin
        sel_code   = 8'hFF;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (step_idx == 3'(i)) begin
                sel_code      = code_all[8*i +: 8];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_anode = (ANODE_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;

    // Next-state logic: load handshake plus IDLE/SCAN sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        pend_val_d  = pend_val_q;
        pend_flag_d = pend_flag_q;
        load_ack_d  = 1'b0;
        code_d      = code_q;
        anode_d     = anode_q;

        if (adopt) begin
            shadow_d    = adopt_val;
            pend_flag_d = 1'b0;
            load_ack_d  = 1'b1;
        end else if (bus.load) begin
            pend_val_d  = bus.value;
            pend_flag_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (bus.enable) begin
                    state_d = SCAN;
                    code_d  = sel_code;
                    anode_d = sel_anode;
                end else begin
                    code_d  = 8'hFF;
                    anode_d = ANODE_OFF;
                end
            end
            SCAN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    code_d  = 8'hFF;
                    anode_d = ANODE_OFF;
                end else if (last_dwell) begin
                    cnt_d   = '0;
                    idx_d   = step_idx;
                    code_d  = sel_code;
                    anode_d = sel_anode;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shadow_q    <= '0;
            pend_val_q  <= '0;
            pend_flag_q <= 1'b0;
            load_ack_q  <= 1'b0;
            code_q      <= 8'hFF;
            anode_q     <= ANODE_OFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            pend_val_q  <= pend_val_d;
            pend_flag_q <= pend_flag_d;
            load_ack_q  <= load_ack_d;
            code_q      <= code_d;
            anode_q     <= anode_d;
        end
    end

    assign bus.load_ack   = load_ack_q;
    assign bus.digit_code = code_q;
    assign bus.anode      = anode_q;
    assign bus.digit_idx  = idx_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus a randomized run,
// all compared against a frame/position-based reference model.
module tb_seg_scan_controller;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;

    seg_scan_controller_if #(.NUM_DIGITS(N)) bus();

    seg_scan_controller #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the scan, displayed/pending numbers
    bit          m_scan;
    bit          m_pend_v;
    bit          m_ack;
    int          m_pos;
    logic [15:0] m_shadow;
    logic [15:0] m_pend;
    logic [7:0]  m_code;
    logic [3:0]  m_anode;
    logic [2:0]  m_idx;

    function automatic logic [7:0] ref_code(logic [15:0] v, int d, bit blz);
        int unsigned nib;
        int unsigned upper;
        upper = int'(v) >> (4 * d);
        nib   = upper % 16;
        if (nib > 9) return 8'hFF;
        if (blz && d != 0 && upper == 0) return 8'hFF;
        return 8'(nib);
    endfunction

    task automatic model_show(int d);
        logic [3:0] a;
        a       = 4'b0001 << d;
        m_idx   = 3'(d);
        m_anode = ~a;
        m_code  = ref_code(m_shadow, d, bus.blank_lz);
    endtask

    task automatic model_dark();
        m_idx   = 3'd0;
        m_anode = 4'hF;
        m_code  = 8'hFF;
    endtask

    task automatic model_load(bit at_boundary);
        if (at_boundary && (bus.load || m_pend_v)) begin
            m_shadow = bus.load ? bus.value : m_pend;
            m_pend_v = 1'b0;
            m_ack    = 1'b1;
        end else if (bus.load) begin
            m_pend   = bus.value;
            m_pend_v = 1'b1;
        end
    endtask

    task automatic model_edge();
        m_ack = 1'b0;
        if (reset) begin
            m_scan = 0; m_pos = 0; m_shadow = 16'h0; m_pend = 16'h0; m_pend_v = 0;
            model_dark();
        end else if (!m_scan) begin
            model_load(1'b1);
            if (bus.enable) begin
                m_scan = 1; m_pos = 0;
                model_show(0);
            end else begin
                model_dark();
            end
        end else if (!bus.enable) begin
            model_load(1'b0);
            m_scan = 0;
            model_dark();
        end else begin
            m_pos++;
            model_load((m_pos % (N * DIV)) == 0);
            if ((m_pos % DIV) == 0) model_show((m_pos / DIV) % N);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.anode !== 4'b1111) begin
            n_errors++; $display("FAIL reset_anode: got %b want 1111", bus.anode);
        end
        n_checks++;
        if (bus.digit_code !== 8'hFF) begin
            n_errors++; $display("FAIL reset_code: got %h want ff", bus.digit_code);
        end
        n_checks++;
        if (bus.load_ack !== 1'b0 || bus.digit_idx !== 3'd0) begin
            n_errors++; $display("FAIL reset_ack_idx: got ack=%b idx=%0d want 0 0", bus.load_ack, bus.digit_idx);
        end
        reset = 1'b0;
        bus.enable = 1'b1;
        tick();
        n_checks++;
        if (bus.anode !== 4'b1110 || bus.digit_code !== 8'h00) begin
            n_errors++; $display("FAIL reset_first_digit: got anode=%b code=%h want 1110 00", bus.anode, bus.digit_code);
        end
        $display("reset done, scanning digit 0 code=%h", bus.digit_code);
    endtask

    task automatic test_scan_timing();
        logic [3:0] ea;
        int d;
        bus.enable = 1'b0;
        tick();
        bus.value = 16'h1234; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++;
        if (bus.load_ack !== 1'b1) begin
            n_errors++; $display("FAIL idle_ack_latency: got ack=%b want 1", bus.load_ack);
        end
        $display("load 1234 in idle, ack=%b one cycle later", bus.load_ack);
        tick();
        n_checks++;
        if (bus.load_ack !== 1'b0) begin
            n_errors++; $display("FAIL ack_single_cycle: got ack=%b want 0", bus.load_ack);
        end
        bus.enable = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            d  = (k / DIV) % N;
            ea = 4'b0001 << d;
            ea = ~ea;
            n_checks++;
            if (bus.digit_code !== 8'(4 - d) || bus.anode !== ea) begin
                n_errors++;
                $display("FAIL scan_timing k=%0d: got code=%h anode=%b want code=%h anode=%b",
                         k, bus.digit_code, bus.anode, 8'(4 - d), ea);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] exp_tab [4][4];
        logic [15:0] vals [4];
        exp_tab = '{'{8'h00, 8'h05, 8'hFF, 8'hFF}, '{8'h00, 8'hFF, 8'hFF, 8'hFF},
                    '{8'h00, 8'h05, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00}};
        vals    = '{16'h0050, 16'h0000, 16'h0050, 16'h0000};
        for (int c = 0; c < 4; c++) begin
            bus.enable = 1'b0;
            tick();
            bus.blank_lz = (c < 2);
            bus.value = vals[c]; bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            bus.enable = 1'b1;
            $display("leading-zero case value=%h blank_lz=%b", vals[c], bus.blank_lz);
            for (int k = 0; k < 16; k++) begin
                tick();
                n_checks++;
                if ({bus.load_ack, bus.digit_code, bus.anode, bus.digit_idx} !== {m_ack, m_code, m_anode, m_idx}) begin
                    n_errors++;
                    $display("FAIL lz_model c=%0d k=%0d: got ack=%b code=%h anode=%b idx=%0d want ack=%b code=%h anode=%b idx=%0d",
                             c, k, bus.load_ack, bus.digit_code, bus.anode, bus.digit_idx, m_ack, m_code, m_anode, m_idx);
                end
                if ((k % DIV) == 0) begin
                    n_checks++;
                    if (bus.digit_code !== exp_tab[c][k / DIV]) begin
                        n_errors++;
                        $display("FAIL lz_table c=%0d digit=%0d: got %h want %h", c, k / DIV, bus.digit_code, exp_tab[c][k / DIV]);
                    end
                end
            end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_tear_free();
        int acks;
        acks = 0;
        bus.enable = 1'b0;
        tick();
        bus.value = 16'h1234; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.enable = 1'b1;
        tick();
        for (int k = 1; k < 16; k++) begin
            bus.load  = (k == 5 || k == 7);
            bus.value = (k == 5) ? 16'h9876 : 16'h5555;
            tick();
            bus.load = 1'b0;
            if (bus.load_ack === 1'b1) acks++;
            if (k >= 4) begin
                n_checks++;
                if (bus.digit_code !== 8'(4 - k / DIV)) begin
                    n_errors++; $display("FAIL tear_old_frame k=%0d: got %h want %h", k, bus.digit_code, 8'(4 - k / DIV));
                end
            end
        end
        n_checks++;
        if (acks != 0) begin
            n_errors++; $display("FAIL tear_early_ack: got %0d acks want 0", acks);
        end
        tick();
        n_checks++;
        if (bus.load_ack !== 1'b1 || bus.digit_code !== 8'h05 || bus.anode !== 4'b1110) begin
            n_errors++; $display("FAIL tear_wrap: got ack=%b code=%h anode=%b want 1 05 1110",
                                 bus.load_ack, bus.digit_code, bus.anode);
        end
        $display("pending load adopted at wrap, ack=%b code=%h", bus.load_ack, bus.digit_code);
        acks = 0;
        for (int k = 17; k < 32; k++) begin
            tick();
            if (bus.load_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_errors++; $display("FAIL tear_second_ack: got %0d extra acks want 0", acks);
        end
        bus.value = 16'h7777; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++;
        if (bus.load_ack !== 1'b1 || bus.digit_code !== 8'h07) begin
            n_errors++; $display("FAIL load_on_wrap: got ack=%b code=%h want 1 07", bus.load_ack, bus.digit_code);
        end
        $display("load 7777 on wrap edge, ack=%b code=%h", bus.load_ack, bus.digit_code);
    endtask

    task automatic test_invalid_nibble();
        logic [7:0] exp_c [4];
        exp_c = '{8'h04, 8'hFF, 8'h02, 8'h01};
        bus.enable = 1'b0;
        tick();
        bus.value = 16'h12A4; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.enable = 1'b1;
        $display("load 12a4 with invalid nibble");
        for (int k = 0; k < 16; k++) begin
            tick();
            if ((k % DIV) == 2) begin
                n_checks++;
                if (bus.digit_code !== exp_c[k / DIV]) begin
                    n_errors++; $display("FAIL invalid_nibble digit=%0d: got %h want %h", k / DIV, bus.digit_code, exp_c[k / DIV]);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        // Scan continues from k=15 of the previous frame; advance into digit 2.
        for (int k = 16; k < 26; k++) tick();
        n_checks++;
        if (bus.digit_idx !== 3'd2) begin
            n_errors++; $display("FAIL drop_setup: got idx=%0d want 2", bus.digit_idx);
        end
        bus.enable = 1'b0;
        tick();
        n_checks++;
        if (bus.anode !== 4'b1111 || bus.digit_code !== 8'hFF || bus.digit_idx !== 3'd0) begin
            n_errors++; $display("FAIL enable_drop: got anode=%b code=%h idx=%0d want 1111 ff 0",
                                 bus.anode, bus.digit_code, bus.digit_idx);
        end
        bus.enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            n_checks++;
            if (bus.digit_idx !== ((j < DIV) ? 3'd0 : 3'd1)) begin
                n_errors++; $display("FAIL reenable_dwell j=%0d: got idx=%0d want %0d", j, bus.digit_idx, (j < DIV) ? 0 : 1);
            end
        end
        $display("enable dropped and restored, dwell restarted at digit 0");
    endtask

    task automatic test_reset_pending();
        int acks;
        acks = 0;
        bus.value = 16'h4321; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.load_ack === 1'b1) acks++;
            if (k == 0) begin
                n_checks++;
                if (bus.digit_code !== 8'h00 || bus.anode !== 4'b1110) begin
                    n_errors++; $display("FAIL reset_shadow: got code=%h anode=%b want 00 1110", bus.digit_code, bus.anode);
                end
            end
        end
        n_checks++;
        if (acks != 0) begin
            n_errors++; $display("FAIL reset_pending_ack: got %0d acks want 0", acks);
        end
        $display("reset with pending load, acks seen=%0d", acks);
    endtask

    task automatic test_random();
        logic [15:0] rv;
        int lead;
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 29) == 0) bus.blank_lz = ~bus.blank_lz;
            bus.load = ($urandom_range(0, 11) == 0);
            lead = $urandom_range(0, 4);
            for (int i = 0; i < 4; i++) begin
                rv[4*i +: 4] = (i >= 4 - lead) ? 4'd0 : 4'($urandom_range(0, 11));
            end
            bus.value = rv;
            tick();
            n_checks++;
            if ({bus.load_ack, bus.digit_code, bus.anode, bus.digit_idx} !== {m_ack, m_code, m_anode, m_idx}) begin
                n_errors++;
                $display("FAIL random c=%0d: got ack=%b code=%h anode=%b idx=%0d want ack=%b code=%h anode=%b idx=%0d",
                         c, bus.load_ack, bus.digit_code, bus.anode, bus.digit_idx, m_ack, m_code, m_anode, m_idx);
            end
            if (m_ack) $display("random load ack at cycle %0d, displayed value %h", c, m_shadow);
        end
        reset = 1'b0;
        bus.load = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.value    = 16'h0;
        bus.blank_lz = 1'b0;
        test_reset();
        test_scan_timing();
        test_leading_zero();
        test_tear_free();
        test_invalid_nibble();
        test_enable_drop();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexed scan controller for the board's shared seven-segment decoder.
- Holds a NUM_DIGITS-digit BCD value, usually the account balance or PIN entry from the bank FSM.
- Drives one digit nibble at a time onto the decoder's 8-bit data input and selects the matching digit anode.
- New values are adopted only at frame boundaries (no tearing), with a load/ack handshake and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; 2..8.
- REFRESH_DIV, 50000: clk cycles each digit is held active; >=2.
- ANODE_ACTIVE_LOW, 1: 1 means a selected anode is driven 0; 0 means selected is driven 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = scan, 0 = display dark (IDLE).
- load  input  1  one-cycle request to display value.
- value  input  4*NUM_DIGITS  BCD nibbles; digit 0 = bits [3:0] (least significant).
- blank_lz  input  1  1 = suppress leading zeros.
- load_ack  output  1  one-cycle pulse when a loaded value becomes the displayed value.
- digit_code  output  8  to decoder data input; {4'b0000, nibble}, or 8'hFF for blank.
- anode  output  NUM_DIGITS  digit select, one-hot in the active polarity.
- digit_idx  output  3  index of the digit currently driven.

Behaviour:
- All outputs are registered.
- Reset (one clk with reset=1): state=IDLE, refresh counter=0, digit_idx=0, shadow=0, pending register=0, pending flag=0, load_ack=0, digit_code=8'hFF, anode all inactive. Reset mid-frame aborts the frame and discards any pending load.
- States: IDLE, SCAN.
- IDLE:
  - Outputs: anode all inactive; digit_code=8'hFF; counter=0; idx=0.
  - If enable=1, the next edge goes to SCAN, driving digit 0 (anode[0] active, code of digit 0) with counter=0.
- SCAN:
  - Counter increments every clk.
  - When counter=REFRESH_DIV-1: counter wraps to 0 and idx advances (NUM_DIGITS-1 wraps to 0). anode and digit_code update on that same edge.
  - Each digit is therefore active for exactly REFRESH_DIV cycles, and one frame is NUM_DIGITS*REFRESH_DIV cycles.
  - If enable=0, the next edge goes to IDLE; this overrides the idx advance.
- Digit code for digit i:
  - If nibble > 9: 8'hFF. The decoder's default case renders this blank.
  - Else if blank_lz=1, i != 0, and nibbles i..NUM_DIGITS-1 are all zero: 8'hFF.
  - Else: {4'b0000, nibble}.
  - Digit 0 is never zero-blanked, so a value of 0 shows "0".
- Load handshake:
  - load=1 captures value into the pending register and sets the pending flag.
  - Adoption point: in SCAN, the edge where idx wraps NUM_DIGITS-1 -> 0; in IDLE, the next edge.
  - At adoption with the pending flag set: shadow <= pending, flag cleared, load_ack=1 for exactly that one cycle.
  - The first digit of the new frame shows the new value.
- Load boundary conditions:
  - Repeated load before adoption: the last value wins; one ack only.
  - load on the adoption edge itself: the incoming value is adopted directly on that edge (bypasses pending), and ack fires.
- Latency:
  - IDLE: load to load_ack is 1 cycle.
  - SCAN: load_ack occurs at the next frame wrap, at most NUM_DIGITS*REFRESH_DIV cycles after load.
- blank_lz and enable are sampled every cycle. A blank_lz change takes effect on the next digit update. A value change without load has no effect.

Test Plan:
- Run with NUM_DIGITS=4, REFRESH_DIV=4, ANODE_ACTIVE_LOW=1.
- Reset: assert reset 2 cycles -> anode=4'b1111, digit_code=8'hFF, load_ack=0. Then enable=1 -> next edge anode=4'b1110, digit_code=8'h00.
- Scan timing: load value=16'h1234 in IDLE -> ack 1 cycle later. Enable -> digit_code 8'h04, 8'h03, 8'h02, 8'h01, each for 4 cycles; anode 1110, 1101, 1011, 0111; repeats every 16 cycles.
- Leading zeros: value=16'h0050, blank_lz=1 -> digits 0..3 = 8'h00, 8'h05, 8'hFF, 8'hFF. value=16'h0000 -> 8'h00, FF, FF, FF. Repeat with blank_lz=0 -> all digits shown.
- Tear-free load:
  - While scanning 16'h1234 at idx=1, load 16'h9876, then load 16'h5555 two cycles later.
  - Rest of frame still shows 3, 2, 1.
  - At the wrap: single load_ack, digit_code=8'h05.
  - Load on the exact wrap edge is adopted on that edge.
- Invalid nibble: value=16'h12A4 -> digit 1 code=8'hFF, others normal.
- Enable drop and reset mid-frame:
  - enable=0 at idx=2 -> next edge anode=4'b1111, digit_code=8'hFF. Re-enable -> restarts at idx 0 with full 4-cycle dwell.
  - Reset with a pending load -> no ack ever fires; shadow=0.
